fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences instruction fetch for the out-of-order front end.
- Issues in-order fetch-block requests to instruction memory, tracks in-flight requests in an in-order buffer, and pairs each returned block with its PC.
- Presents each completed block to the precoder over the fetch_response valid/ready interface.
- On flush, discards buffered and in-flight blocks and restarts fetch from the redirect PC.

Parameters:
- XLEN, 64, address width.
- INPUT_INST, 4, 16-bit parcels per fetch block; block stride = 2*INPUT_INST bytes.
- MAX_OUTSTANDING, 4, buffer depth; caps requested-but-not-consumed blocks (power of two, ≥2).
- RESET_PC, 0, first fetch PC after reset.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  redirect; sampled on rising edge.
- flush_PC  input  XLEN  restart PC, valid with flush.
- fetch_request_valid  output  1  memory request valid.
- fetch_request_ready  input  1  memory accepts request.
- fetch_request_PC  output  XLEN  request address.
- mem_response_valid  input  1  memory returns one block; in request order; no backpressure.
- mem_response_data  input  16*INPUT_INST  returned block.
- fetch_response_valid  output  1  block available to precoder.
- fetch_response_ready  input  1  precoder accepts block.
- fetch_response_data  output  16*INPUT_INST  head block data.
- fetch_response_PC  output  XLEN  head block PC.
- outstanding_count  output  log2(MAX_OUTSTANDING)+1  allocated buffer entries (debug/perf).

Behaviour:
- **Reset (reset=0, asynchronous):**
  - next_PC=RESET_PC, state=IDLE, all entries invalid, count=0, drop_count=0.
  - fetch_request_valid=0, fetch_response_valid=0, fetch_response_data=0, fetch_response_PC=0, outstanding_count=0.
  - Reset asserted mid-operation discards everything immediately; no completion of pending transfers.
- **States:**
  - IDLE: one cycle after reset release, no requests; then unconditionally to RUN.
  - RUN: normal operation.
  - flush in IDLE is honoured: next_PC=flush_PC, state still goes to RUN.
- **Buffer:** circular, MAX_OUTSTANDING entries of {PC, data, filled}; alloc pointer, fill pointer, head pointer, each wraps modulo depth.
- **Issue:**
  - fetch_request_valid = (state==RUN) && (count<MAX_OUTSTANDING) && !flush.
  - fetch_request_PC = next_PC.
  - On valid&&ready: allocate entry with PC=next_PC, filled=0; next_PC += 2*INPUT_INST (wraps modulo 2^XLEN); count++.
  - fetch_request_valid, once asserted, holds with stable PC until accepted, unless flush.
- **Response:**
  - On mem_response_valid with drop_count>0: drop_count--, data discarded.
  - Otherwise the entry at the fill pointer gets data, filled=1, and the fill pointer advances.
  - mem_response_valid with no unfilled entry and drop_count==0 is a protocol violation; it is ignored and state is unchanged.
- **Deliver:**
  - fetch_response_valid = head entry allocated && filled; data/PC driven from head entry.
  - Latency: response accepted at edge N → fetch_response_valid high after edge N (earliest visible cycle N+1).
  - On valid&&ready: free head, head advances, count--.
  - Outputs are stable while valid && !ready.
- **Simultaneous events:**
  - Issue and deliver in the same cycle: count unchanged.
  - Full buffer with delivery in the same cycle: no issue that cycle, because valid uses the registered count.
- **Flush (RUN or IDLE):**
  - All entries invalidated; pointers reset to 0; count=0.
  - drop_count += number of allocated-unfilled entries.
  - next_PC=flush_PC (not realigned).
  - fetch_request_valid forced 0 in the flush cycle.
  - fetch_response_valid forced 0 in the flush cycle; a handshake in that cycle does not transfer.
  - A mem response in the flush cycle counts as stale: it is dropped, and its entry is not added to drop_count.
  - The first new request is issued the cycle after flush.
  - Back-to-back flushes accumulate drop_count correctly.
- **drop_count** is wide enough for MAX_OUTSTANDING×2 and never underflows.

Test Plan:
1. **Reset then free-run:** reset low 5 cycles, release; fetch_request_ready=1, memory returns each request 2 cycles later, precoder_ready=1.
   - Requests issue at PCs 0,8,16,24.
   - fetch_response_PC sequence 0,8,16,24 with matching data.
   - outstanding_count never exceeds 4.
2. **Backpressure/full:** fetch_response_ready=0, memory responds to all.
   - After 4 accepted requests, fetch_request_valid=0 and outstanding_count=4.
   - Head holds PC 0 stable.
   - Raise ready for 1 cycle → head becomes PC 8 and one new request issues, at PC 32.
3. **Flush with in-flight:** 3 requests at PC 0,8,16 accepted, 1 response returned; assert flush with flush_PC=100.
   - The 2 later responses are dropped.
   - Next request is PC 100, then 108.
   - First delivered block has PC 100 with the data of the 4th response.
4. **Flush coincident with response and delivery:** flush, mem_response_valid and fetch_response_ready in the same cycle.
   - No delivery that cycle and fetch_response_valid=0.
   - Response dropped; drop_count equals the unfilled entries excluding that response.
5. **Request held:** fetch_request_ready=0 for 5 cycles.
   - fetch_request_valid stays 1 and fetch_request_PC constant at 8 throughout; count unchanged until accept.
6. **Reset mid-stream:** 3 entries outstanding, reset pulsed low between edges.
   - Outputs go to 0 immediately (asynchronously).
   - After release: one IDLE cycle, then a request at RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - in-order instruction fetch sequencer with outstanding-block buffer
module fetch_controller #(
  parameter int unsigned       XLEN            = 64,
  parameter int unsigned       INPUT_INST      = 4,
  parameter int unsigned       MAX_OUTSTANDING = 4,
  parameter logic [XLEN-1:0]   RESET_PC        = '0
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [XLEN-1:0]                       flush_PC,
  output logic                                  fetch_request_valid,
  input  logic                                  fetch_request_ready,
  output logic [XLEN-1:0]                       fetch_request_PC,
  input  logic                                  mem_response_valid,
  input  logic [16*INPUT_INST-1:0]              mem_response_data,
  output logic                                  fetch_response_valid,
  input  logic                                  fetch_response_ready,
  output logic [16*INPUT_INST-1:0]              fetch_response_data,
  output logic [XLEN-1:0]                       fetch_response_PC,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_count
);

  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = PW + 1;
  localparam int DW  = 16 * INPUT_INST;
  localparam int DCW = $clog2(2 * MAX_OUTSTANDING) + 1;
  localparam logic [XLEN-1:0] STRIDE = XLEN'(2 * INPUT_INST);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state_q, state_d;
  logic [XLEN-1:0]            next_pc_q;
  logic [PW-1:0]              alloc_ptr, fill_ptr, head_ptr;
  logic [CW-1:0]              count_q;
  logic [CW-1:0]              pending_q;
  logic [DCW-1:0]             drop_q;
  logic [MAX_OUTSTANDING-1:0] alloc_q, filled_q;
  logic [XLEN-1:0]            pc_q   [MAX_OUTSTANDING];
  logic [DW-1:0]              data_q [MAX_OUTSTANDING];

  logic issue, deliver, fill, stale;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    fetch_request_valid  = 1'b0;
    fetch_response_valid = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN:  fetch_request_valid = (count_q < CW'(MAX_OUTSTANDING)) && !flush;
      default: state_d = IDLE;
    endcase
    fetch_response_valid = alloc_q[head_ptr] && filled_q[head_ptr] && !flush;
  end

  assign issue   = fetch_request_valid && fetch_request_ready;
  assign deliver = fetch_response_valid && fetch_response_ready;
  assign fill    = mem_response_valid && (drop_q == '0) && (pending_q != '0);
  // A response landing in the flush cycle retires either a pending drop or the oldest unfilled entry.
  assign stale   = mem_response_valid && ((drop_q != '0) || (pending_q != '0));

  assign fetch_request_PC    = next_pc_q;
  assign fetch_response_data = data_q[head_ptr];
  assign fetch_response_PC   = pc_q[head_ptr];
  assign outstanding_count   = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      next_pc_q <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      drop_q    <= '0;
      alloc_q   <= '0;
      filled_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      next_pc_q <= flush_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      alloc_q   <= '0;
      filled_q  <= '0;
      drop_q    <= drop_q + DCW'(pending_q) - DCW'(stale);
    end else begin
      if (issue) begin
        alloc_q[alloc_ptr]  <= 1'b1;
        filled_q[alloc_ptr] <= 1'b0;
        pc_q[alloc_ptr]     <= next_pc_q;
        alloc_ptr           <= alloc_ptr + PW'(1);
        next_pc_q           <= next_pc_q + STRIDE;
      end
      if (mem_response_valid && (drop_q != '0)) begin
        drop_q <= drop_q - DCW'(1);
      end else if (fill) begin
        filled_q[fill_ptr] <= 1'b1;
        data_q[fill_ptr]   <= mem_response_data;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      // Head is already filled, so it never aliases the fill or alloc slot here.
      if (deliver) begin
        alloc_q[head_ptr]  <= 1'b0;
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PW'(1);
      end
      count_q   <= count_q + CW'(issue) - CW'(deliver);
      pending_q <= pending_q + CW'(issue) - CW'(fill);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
module tb_fetch_controller;

  localparam int XLEN       = 64;
  localparam int INPUT_INST = 4;
  localparam int MAXO       = 4;
  localparam int DW         = 16 * INPUT_INST;
  localparam logic [63:0] DATA_BASE = 64'hDA7A_0000_0000_0000;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic [XLEN-1:0] flush_PC;
  logic            fetch_request_valid;
  logic            fetch_request_ready;
  logic [XLEN-1:0] fetch_request_PC;
  logic            mem_response_valid;
  logic [DW-1:0]   mem_response_data;
  logic            fetch_response_valid;
  logic            fetch_response_ready;
  logic [DW-1:0]   fetch_response_data;
  logic [XLEN-1:0] fetch_response_PC;
  logic [2:0]      outstanding_count;

  fetch_controller #(
    .XLEN(XLEN), .INPUT_INST(INPUT_INST), .MAX_OUTSTANDING(MAXO), .RESET_PC('0)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .flush_PC(flush_PC),
    .fetch_request_valid(fetch_request_valid), .fetch_request_ready(fetch_request_ready),
    .fetch_request_PC(fetch_request_PC),
    .mem_response_valid(mem_response_valid), .mem_response_data(mem_response_data),
    .fetch_response_valid(fetch_response_valid), .fetch_response_ready(fetch_response_ready),
    .fetch_response_data(fetch_response_data), .fetch_response_PC(fetch_response_PC),
    .outstanding_count(outstanding_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [63:0] pc; logic [63:0] data; } blk_t;

  logic [63:0] pend_q[$];
  blk_t        done_q[$];
  int          m_drop;
  bit          m_run;
  logic [63:0] m_next_pc;
  bit          m_issued;

  int          due_q[$];
  int          cyc;
  int          resp_idx;

  logic [63:0] got_pcs[$];
  logic [63:0] req_pcs[$];
  int          max_out;

  int          n_chk;
  int          n_fail;
  bit          c_erv, c_esv;

  function automatic int m_count();
    return pend_q.size() + done_q.size();
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    done_q.delete();
    m_drop    = 0;
    m_run     = 0;
    m_next_pc = '0;
    m_issued  = 0;
  endtask

  task automatic model_update();
    bit   iss, dlv;
    blk_t b;
    if (!reset) begin
      model_reset();
      return;
    end
    iss = m_run && (m_count() < MAXO) && !flush && fetch_request_ready;
    dlv = (done_q.size() > 0) && !flush && fetch_response_ready;
    m_issued = 0;
    if (flush) begin
      if (mem_response_valid) begin
        if (m_drop > 0) m_drop--;
        else if (pend_q.size() > 0) void'(pend_q.pop_front());
      end
      m_drop += pend_q.size();
      pend_q.delete();
      done_q.delete();
      m_next_pc = flush_PC;
    end else begin
      if (dlv) void'(done_q.pop_front());
      if (mem_response_valid) begin
        if (m_drop > 0) m_drop--;
        else if (pend_q.size() > 0) begin
          b.pc   = pend_q.pop_front();
          b.data = mem_response_data;
          done_q.push_back(b);
        end
      end
      if (iss) begin
        pend_q.push_back(m_next_pc);
        m_next_pc = m_next_pc + 64'(2 * INPUT_INST);
        m_issued  = 1;
      end
    end
    m_run = 1;
  endtask

  // Model advances on the edge; memory answers each accepted request two edges later.
  task automatic tick();
    @(posedge clock);
    model_update();
    cyc++;
    if (m_issued) due_q.push_back(cyc + 2);
    #1;
    if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
      void'(due_q.pop_front());
      mem_response_valid = 1'b1;
      mem_response_data  = DATA_BASE | 64'(resp_idx);
      resp_idx++;
    end else begin
      mem_response_valid = 1'b0;
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic reset_dut(input int n);
    reset                = 1'b0;
    flush                = 1'b0;
    flush_PC             = '0;
    fetch_request_ready  = 1'b0;
    fetch_response_ready = 1'b0;
    mem_response_valid   = 1'b0;
    mem_response_data    = '0;
    due_q.delete();
    resp_idx = 0;
    model_reset();
    tick();
    settle();
    check("rst_req_valid", fetch_request_valid, 0);
    check("rst_resp_valid", fetch_response_valid, 0);
    check("rst_resp_data", fetch_response_data, 0);
    check("rst_resp_pc", fetch_response_PC, 0);
    check("rst_count", outstanding_count, 0);
    repeat (n - 1) tick();
    reset = 1'b1;
    got_pcs.delete();
    req_pcs.delete();
    max_out = 0;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      c_erv = m_run && (m_count() < MAXO) && !flush;
      c_esv = (done_q.size() > 0) && !flush;
      check("req_valid", fetch_request_valid, c_erv);
      if (c_erv) check("req_pc", fetch_request_PC, m_next_pc);
      check("resp_valid", fetch_response_valid, c_esv);
      if (c_esv) begin
        check("resp_pc", fetch_response_PC, done_q[0].pc);
        check("resp_data", fetch_response_data, done_q[0].data);
      end
      check("outstanding", outstanding_count, m_count());
      if (fetch_response_valid && fetch_response_ready) got_pcs.push_back(fetch_response_PC);
      if (fetch_request_valid && fetch_request_ready) req_pcs.push_back(fetch_request_PC);
      if (int'(outstanding_count) > max_out) max_out = int'(outstanding_count);
    end
  end

  initial begin
    logic [63:0] g;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;

    // Free run
    reset_dut(5);
    fetch_request_ready  = 1'b1;
    fetch_response_ready = 1'b1;
    settle();
    check("t1_idle_no_req", fetch_request_valid, 0);
    repeat (12) tick();
    check("t1_four_delivered", got_pcs.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      g = (got_pcs.size() > i) ? got_pcs[i] : '1;
      check("t1_resp_pc_seq", g, 64'(i * 8));
      g = (req_pcs.size() > i) ? req_pcs[i] : '1;
      check("t1_req_pc_seq", g, 64'(i * 8));
    end
    check("t1_max_outstanding", max_out <= 4, 1);

    // Backpressure until full
    reset_dut(3);
    fetch_request_ready = 1'b1;
    repeat (10) tick();
    settle();
    check("t2_full_req_valid", fetch_request_valid, 0);
    check("t2_full_count", outstanding_count, 4);
    check("t2_head_valid", fetch_response_valid, 1);
    check("t2_head_pc", fetch_response_PC, 0);
    check("t2_head_data", fetch_response_data, DATA_BASE);
    fetch_response_ready = 1'b1;
    tick();
    fetch_response_ready = 1'b0;
    settle();
    check("t2_next_head_pc", fetch_response_PC, 8);
    check("t2_next_head_data", fetch_response_data, DATA_BASE + 1);
    check("t2_reopen_req_valid", fetch_request_valid, 1);
    check("t2_reopen_req_pc", fetch_request_PC, 32);
    check("t2_count_after_pop", outstanding_count, 3);
    tick();
    settle();
    check("t2_refull_count", outstanding_count, 4);
    check("t2_refull_req_valid", fetch_request_valid, 0);

    // Flush with requests in flight
    reset_dut(3);
    tick();
    fetch_request_ready = 1'b1;
    repeat (3) tick();
    flush    = 1'b1;
    flush_PC = 64'd100;
    settle();
    check("t3_flush_req_valid", fetch_request_valid, 0);
    check("t3_flush_resp_valid", fetch_response_valid, 0);
    tick();
    flush = 1'b0;
    settle();
    check("t3_restart_pc", fetch_request_PC, 100);
    check("t3_restart_valid", fetch_request_valid, 1);
    check("t3_count_cleared", outstanding_count, 0);
    tick();
    settle();
    check("t3_second_pc", fetch_request_PC, 108);
    repeat (2) tick();
    settle();
    check("t3_first_valid", fetch_response_valid, 1);
    check("t3_first_pc", fetch_response_PC, 100);
    check("t3_first_data", fetch_response_data, DATA_BASE + 3);
    fetch_response_ready = 1'b1;
    repeat (4) tick();
    g = (got_pcs.size() > 0) ? got_pcs[0] : '1;
    check("t3_first_delivered", g, 100);

    // Flush coincident with a response and a ready precoder
    reset_dut(3);
    fetch_request_ready = 1'b1;
    repeat (5) tick();
    flush                = 1'b1;
    flush_PC             = 64'd200;
    fetch_response_ready = 1'b1;
    settle();
    check("t4_resp_in_flush_cycle", mem_response_valid, 1);
    check("t4_flush_resp_valid", fetch_response_valid, 0);
    tick();
    flush = 1'b0;
    settle();
    check("t4_no_transfer", got_pcs.size(), 0);
    check("t4_count_cleared", outstanding_count, 0);
    check("t4_restart_pc", fetch_request_PC, 200);
    repeat (3) tick();
    settle();
    check("t4_new_valid", fetch_response_valid, 1);
    check("t4_new_pc", fetch_response_PC, 200);
    check("t4_new_data", fetch_response_data, DATA_BASE + 4);
    repeat (3) tick();

    // Request held under memory backpressure
    reset_dut(3);
    fetch_request_ready = 1'b1;
    repeat (2) tick();
    fetch_request_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t5_hold_valid", fetch_request_valid, 1);
      check("t5_hold_pc", fetch_request_PC, 8);
      check("t5_hold_count", outstanding_count, 1);
      tick();
    end
    fetch_request_ready = 1'b1;
    tick();
    settle();
    check("t5_accept_count", outstanding_count, 2);
    check("t5_accept_next_pc", fetch_request_PC, 16);

    // Asynchronous reset mid-stream
    tick();
    settle();
    check("t6_pre_count", outstanding_count, 3);
    check("t6_pre_resp_valid", fetch_response_valid, 1);
    reset = 1'b0;
    #1;
    check("t6_async_req_valid", fetch_request_valid, 0);
    check("t6_async_resp_valid", fetch_response_valid, 0);
    check("t6_async_resp_data", fetch_response_data, 0);
    check("t6_async_resp_pc", fetch_response_PC, 0);
    check("t6_async_count", outstanding_count, 0);
    fetch_request_ready = 1'b1;
    due_q.delete();
    resp_idx = 0;
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    settle();
    check("t6_idle_req_valid", fetch_request_valid, 0);
    tick();
    settle();
    check("t6_run_req_valid", fetch_request_valid, 1);
    check("t6_run_req_pc", fetch_request_PC, 0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
